// File: rtl/apb_noc_initiator.sv
// ----------------------------------------------------------------------------
// apb_noc_initiator
//
// Bridges a local APB master onto a NoC router port. An APB access is turned
// into a 6-flit request packet (head, body0..body3, tail), the block then waits
// for the matching 6-flit response packet and completes the APB transfer with
// a single-cycle pready pulse. One transfer is outstanding at a time.
//
// Parameters
//   NODE_ID         this node's NoC id (request src, response dest match)
//   TIMEOUT_CYCLES  WAIT_RESP cycles before completing with pslverr=1
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   psel, penable      APB select / access phase from the local master
//   pwrite             1 = write, 0 = read
//   paddr, pwdata      APB address / write data
//   pready             one-cycle completion pulse
//   prdata, pslverr    read data / error, valid only while pready=1
//   o_flit, valid_out  request flit toward the NoC and its valid
//   noc_ready          NoC accepts o_flit this cycle
//   i_flit, enable     response flit from the NoC and its valid (no backpressure)
// ----------------------------------------------------------------------------
module apb_noc_initiator #(
    parameter logic [3:0] NODE_ID        = 4'h0,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic [15:0] o_flit,
    output logic        valid_out,
    input  logic        noc_ready,
    input  logic [15:0] i_flit,
    input  logic        enable
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND      = 3'd1;
    localparam logic [2:0] WAIT_RESP = 3'd2;
    localparam logic [2:0] RECV      = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    localparam int              TCNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W:0] TIMEOUT_LIM = TIMEOUT_CYCLES[TCNT_W:0];

    logic [2:0]        state;
    logic [2:0]        flit_cnt;
    logic [2:0]        rx_cnt;
    logic [TCNT_W-1:0] tcnt;
    logic              err;

    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              write;
    logic [31:0]       rdata;

    logic [15:0]       flit;
    logic              head_ok;
    logic [TCNT_W:0]   tcnt_inc;
    logic              timeout_hit;

    // Response head: addressed to us and typed as a response.
    assign head_ok     = enable && (i_flit[15:12] == NODE_ID) && (i_flit[7:6] == 2'b10);
    // Extra bit on the increment keeps the >= compare free of wrap-around;
    // the transition fires on the cycle whose increment reaches the limit,
    // so WAIT_RESP lasts exactly TIMEOUT_CYCLES cycles.
    assign tcnt_inc    = {1'b0, tcnt} + {{TCNT_W{1'b0}}, 1'b1};
    assign timeout_hit = (tcnt_inc >= TIMEOUT_LIM);

    // Request flit selected by flit_cnt; a read sends zero write data.
    always_comb begin
        flit = 16'h0000;
        case (flit_cnt)
            3'd0:    flit = {addr[31:28], NODE_ID, (write ? 2'b01 : 2'b00), 6'b000000};
            3'd1:    flit = addr[31:16];
            3'd2:    flit = addr[15:0];
            3'd3:    flit = write ? wdata[31:16] : 16'h0000;
            3'd4:    flit = write ? wdata[15:0]  : 16'h0000;
            default: flit = 16'h0000;
        endcase
    end

    // Outputs decode straight from the registered state, so an asynchronous
    // reset clears them immediately.
    assign valid_out = (state == SEND);
    assign o_flit    = valid_out ? flit : 16'h0000;
    assign pready    = (state == DONE);
    assign prdata    = pready ? rdata : 32'h0;
    assign pslverr   = pready ? err : 1'b0;

    // ---- control: FSM, counters, error flag ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            flit_cnt <= 3'd0;
            rx_cnt   <= 3'd0;
            tcnt     <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel && penable) begin
                        flit_cnt <= 3'd0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (noc_ready) begin
                        if (flit_cnt == 3'd5) begin
                            flit_cnt <= 3'd0;
                            tcnt     <= '0;
                            state    <= WAIT_RESP;
                        end else begin
                            flit_cnt <= flit_cnt + 3'd1;
                        end
                    end
                end
                WAIT_RESP: begin
                    tcnt <= tcnt_inc[TCNT_W-1:0];
                    if (head_ok) begin
                        rx_cnt <= 3'd1;
                        state  <= RECV;
                    end else if (timeout_hit) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end
                end
                RECV: begin
                    if (enable) begin
                        rx_cnt <= rx_cnt + 3'd1;
                        if (rx_cnt == 3'd5) begin
                            err   <= i_flit[0];
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    rx_cnt <= 3'd0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- datapath: request latch and response capture ----
    always_ff @(posedge clk) begin
        if (state == IDLE && psel && penable) begin
            addr  <= paddr;
            wdata <= pwdata;
            write <= pwrite;
        end
        if (state == WAIT_RESP && !head_ok && timeout_hit) begin
            rdata <= 32'h0;
        end
        if (state == RECV && enable) begin
            if (rx_cnt == 3'd1) rdata[31:16] <= i_flit;
            if (rx_cnt == 3'd2) rdata[15:0]  <= i_flit;
        end
    end

endmodule

// File: tb/tb_apb_noc_initiator.sv
module tb_apb_noc_initiator;

    logic        clk = 1'b0;
    logic        resetn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [15:0] o_flit;
    logic        valid_out;
    logic        noc_ready;
    logic [15:0] i_flit;
    logic        enable;

    apb_noc_initiator dut (
        .clk       (clk),
        .resetn    (resetn),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr),
        .o_flit    (o_flit),
        .valid_out (valid_out),
        .noc_ready (noc_ready),
        .i_flit    (i_flit),
        .enable    (enable)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] MY_ID = 4'h0;

    typedef struct packed {
        logic             w;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [1:0]       bp;       // 0 ready, 1 pattern 1,0,0,1, 2 random
        logic             noise;    // drive a fake response head during SEND
        logic [0:5][15:0] resp;
        logic [0:5][15:0] exp_flit;
        logic [31:0]      exp_rdata;
        logic             exp_err;
    } vec_t;

    vec_t tbl[3];

    int nchk = 0;
    int nfail = 0;

    logic [15:0] rsp_flit_q[$];
    logic        rsp_en_q[$];
    logic [15:0] sent_q[$];
    int          tail_step, pready_step, last_rsp_step, pready_cnt, stall_viol;
    logic [31:0] obs_rdata;
    logic        obs_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference request packet built from the field layout with plain arithmetic.
    function automatic logic [15:0] model_flit(input int i, input logic w,
                                               input logic [31:0] a, input logic [31:0] d);
        case (i)
            0: return 16'(((a >> 28) << 12) | (32'(MY_ID) << 8) | (w ? 32'd64 : 32'd0));
            1: return 16'(a >> 16);
            2: return 16'(a % 65536);
            3: return w ? 16'(d >> 16) : 16'h0;
            4: return w ? 16'(d % 65536) : 16'h0;
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic pick_ready(input int bp, input int step);
        case (bp)
            0: return 1'b1;
            1: return (step % 4 == 0) || (step % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic push_rsp(input logic en, input logic [15:0] f);
        rsp_en_q.push_back(en);
        rsp_flit_q.push_back(f);
    endtask

    // One APB transfer; responses queued in rsp_*_q are played out after the tail.
    task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input int bp, input bit noise, input bit drop_psel);
        int   step;
        bit   resp_on;
        bit   prev_stalled;
        logic [15:0] prev_flit;
        sent_q.delete();
        pready_cnt = 0; stall_viol = 0; tail_step = -1; pready_step = -1;
        last_rsp_step = -1; prev_stalled = 0; resp_on = 0; prev_flit = '0;
        obs_rdata = 32'hxxxx_xxxx; obs_err = 1'bx;
        psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
        enable = 0; noc_ready = 0; i_flit = '0;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        step = 0;
        while (step < 3000) begin
            if (pready === 1'b1) begin
                pready_cnt++;
                if (pready_step < 0) begin
                    pready_step = step;
                    obs_rdata   = prdata;
                    obs_err     = pslverr;
                end
                psel = 0; penable = 0;
            end
            if (pready_step >= 0 && step >= pready_step + 2) break;
            if (drop_psel && step == 2) begin psel = 0; penable = 0; end
            enable = 0; i_flit = '0;
            if (resp_on && rsp_en_q.size() > 0) begin
                enable = rsp_en_q.pop_front();
                i_flit = rsp_flit_q.pop_front();
                if (rsp_en_q.size() == 0) last_rsp_step = step;
            end else if (!resp_on && noise) begin
                enable = 1; i_flit = {MY_ID, 4'h0, 2'b10, 6'h0};
            end
            if (valid_out === 1'b1) begin
                noc_ready = pick_ready(bp, step);
                if (prev_stalled && o_flit !== prev_flit) stall_viol++;
                if (noc_ready) begin
                    sent_q.push_back(o_flit);
                    if (sent_q.size() == 6) begin tail_step = step; resp_on = 1; end
                    prev_stalled = 0;
                end else begin
                    prev_stalled = 1; prev_flit = o_flit;
                end
            end else begin
                noc_ready = 0;
            end
            @(posedge clk); #1;
            step++;
        end
        psel = 0; penable = 0; enable = 0; noc_ready = 0;
        rsp_en_q.delete(); rsp_flit_q.delete();
    endtask

    task automatic verify(input string tag, input logic [0:5][15:0] exp_f,
                          input logic [31:0] exp_rd, input logic exp_e, input bit timeout);
        check({tag, " flit count"}, sent_q.size(), 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("%s flit%0d", tag, k),
                  (k < sent_q.size()) ? {16'h0, sent_q[k]} : 32'hBAD0_0000, {16'h0, exp_f[k]});
        check({tag, " stall hold"}, stall_viol, 0);
        check({tag, " pready pulses"}, pready_cnt, 1);
        check({tag, " prdata"}, obs_rdata, exp_rd);
        check({tag, " pslverr"}, {31'h0, obs_err}, {31'h0, exp_e});
        if (timeout) check({tag, " timeout latency"}, pready_step - (tail_step + 1), 255);
        else         check({tag, " resp latency"}, pready_step, last_rsp_step + 1);
    endtask

    initial begin
        logic [0:5][15:0] ef;
        logic [15:0]      rf[6];
        logic             w;
        logic [31:0]      a, d;

        // write (spec example)
        tbl[0].w = 1; tbl[0].addr = 32'h3000_0010; tbl[0].wdata = 32'hDEAD_BEEF;
        tbl[0].bp = 0; tbl[0].noise = 0;
        tbl[0].resp = {16'h0080, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000};
        tbl[0].exp_flit = {16'h3040, 16'h3000, 16'h0010, 16'hDEAD, 16'hBEEF, 16'h0000};
        tbl[0].exp_rdata = 32'h0; tbl[0].exp_err = 0;
        // read (spec example)
        tbl[1].w = 0; tbl[1].addr = 32'h2000_0004; tbl[1].wdata = 32'hFFFF_FFFF;
        tbl[1].bp = 0; tbl[1].noise = 0;
        tbl[1].resp = {16'h0080, 16'h1234, 16'h5678, 16'hFFFF, 16'hFFFF, 16'h0001};
        tbl[1].exp_flit = {16'h2000, 16'h2000, 16'h0004, 16'h0000, 16'h0000, 16'h0000};
        tbl[1].exp_rdata = 32'h1234_5678; tbl[1].exp_err = 1;
        // backpressure 1,0,0,1 with response-looking noise during SEND
        tbl[2].w = 1; tbl[2].addr = 32'hF123_4567; tbl[2].wdata = 32'h0BAD_F00D;
        tbl[2].bp = 1; tbl[2].noise = 1;
        tbl[2].resp = {16'h0080, 16'hCAFE, 16'hBABE, 16'h0001, 16'h0002, 16'h0000};
        tbl[2].exp_flit = {16'hF040, 16'hF123, 16'h4567, 16'h0BAD, 16'hF00D, 16'h0000};
        tbl[2].exp_rdata = 32'hCAFE_BABE; tbl[2].exp_err = 0;

        resetn = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        noc_ready = 0; i_flit = '0; enable = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset valid_out", {31'h0, valid_out}, 0);
        check("reset o_flit", {16'h0, o_flit}, 0);
        check("reset pready", {31'h0, pready}, 0);
        check("reset prdata", prdata, 0);
        check("reset pslverr", {31'h0, pslverr}, 0);
        resetn = 1;
        @(posedge clk); #1;
        check("idle valid_out", {31'h0, valid_out}, 0);

        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 6; k++) push_rsp(1'b1, tbl[i].resp[k]);
            run_xfer(tbl[i].w, tbl[i].addr, tbl[i].wdata, int'(tbl[i].bp), tbl[i].noise, 0);
            verify($sformatf("vec%0d", i), tbl[i].exp_flit, tbl[i].exp_rdata, tbl[i].exp_err, 0);
        end

        // Timeout: no response at all.
        run_xfer(0, 32'h1000_0000, 32'h0, 0, 0, 0);
        for (int k = 0; k < 6; k++) ef[k] = model_flit(k, 0, 32'h1000_0000, 32'h0);
        verify("timeout", ef, 32'h0, 1, 1);

        // Foreign packet, then our response with enable gaps; psel dropped early.
        push_rsp(1, 16'h5080); push_rsp(1, 16'h1111); push_rsp(1, 16'h2222);
        push_rsp(1, 16'h3333); push_rsp(1, 16'h4444); push_rsp(1, 16'h0000);
        push_rsp(0, 16'h0080); push_rsp(1, 16'h0080); push_rsp(1, 16'hA5A5);
        push_rsp(0, 16'hFFFF); push_rsp(1, 16'h5A5A); push_rsp(0, 16'h0001);
        push_rsp(1, 16'h9999); push_rsp(1, 16'h8888); push_rsp(0, 16'h0001);
        push_rsp(1, 16'h0000);
        run_xfer(0, 32'h7000_00AC, 32'h0, 0, 0, 1);
        for (int k = 0; k < 6; k++) ef[k] = model_flit(k, 0, 32'h7000_00AC, 32'h0);
        verify("foreign", ef, 32'hA5A5_5A5A, 0, 0);

        // Reset mid-SEND after three flits.
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h4000_0020; pwdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        noc_ready = 1;
        repeat (3) @(posedge clk);
        #2;
        resetn = 0;
        #1;
        check("midrst valid_out", {31'h0, valid_out}, 0);
        check("midrst o_flit", {16'h0, o_flit}, 0);
        check("midrst pready", {31'h0, pready}, 0);
        check("midrst prdata", prdata, 0);
        check("midrst pslverr", {31'h0, pslverr}, 0);
        psel = 0; penable = 0; noc_ready = 0;
        @(posedge clk); #1;
        resetn = 1;
        @(posedge clk); #1;
        push_rsp(1, 16'h0080); push_rsp(1, 16'h0102); push_rsp(1, 16'h0304);
        push_rsp(1, 16'h0); push_rsp(1, 16'h0); push_rsp(1, 16'h0);
        run_xfer(1, 32'h5000_0040, 32'h2468_ACE0, 0, 0, 0);
        for (int k = 0; k < 6; k++) ef[k] = model_flit(k, 1, 32'h5000_0040, 32'h2468_ACE0);
        verify("after_rst", ef, 32'h0102_0304, 0, 0);

        // Randomized transfers against the reference model.
        for (int r = 0; r < 8; r++) begin
            w = 1'($urandom_range(0, 1)); a = $urandom; d = $urandom;
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                logic [15:0] junk;
                junk = 16'($urandom);
                if (junk[15:12] == MY_ID && junk[7:6] == 2'b10) junk[15:12] = MY_ID + 4'h1;
                push_rsp(1'($urandom_range(0, 1)), junk);
            end
            rf[0] = {MY_ID, 4'($urandom), 2'b10, 6'($urandom)};
            for (int k = 1; k < 6; k++) rf[k] = 16'($urandom);
            for (int k = 0; k < 6; k++) begin
                if (k > 0 && $urandom_range(0, 2) == 0) push_rsp(0, 16'($urandom));
                push_rsp(1, rf[k]);
            end
            run_xfer(w, a, d, 2, 0, 0);
            for (int k = 0; k < 6; k++) ef[k] = model_flit(k, w, a, d);
            verify($sformatf("rand%0d", r), ef, {rf[1], rf[2]}, rf[5][0], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
